// File: rtl/dmem_responder_if.sv
// Data-port bundle between the CPU M stage and the memory responder.
// The master side raises requests; the slave side answers and stalls.
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic        byte_op;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        read_valid;
    logic        stall;
    logic        addr_error;

    modport master (
        output mem_read, mem_write, byte_op, address, write_data,
        input  read_data, read_valid, stall, addr_error
    );

    modport slave (
        input  mem_read, mem_write, byte_op, address, write_data,
        output read_data, read_valid, stall, addr_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the M-stage data port: word/byte access to a local
// 16-bit array with WAIT_CYCLES stall cycles per access and address-error flagging.
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset_n,
    dmem_responder_if.slave bus
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    op_e         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        byte_q, byte_d;
    logic        err_q, err_d;
    logic [15:0] read_data_q, read_data_d;
    logic [15:0] mem_q [DEPTH];

    function automatic logic addr_bad(input logic [15:0] a, input logic is_byte);
        return (!is_byte && a[0]) || ((a >> (ADDR_BITS + 1)) != 16'h0000);
    endfunction

    logic                 in_idle;
    logic                 req;
    logic                 both_req;
    op_e                  live_op;
    op_e                  cur_op;
    logic [15:0]          cur_addr;
    logic [15:0]          cur_wdata;
    logic                 cur_byte;
    logic                 cur_err;
    logic [ADDR_BITS-1:0] cur_idx;
    logic [15:0]          rd_word;
    logic [15:0]          load_value;
    logic                 fast_done;
    logic                 slow_done;
    logic                 wr_en;

    assign in_idle  = (state_q == ST_IDLE);
    assign req      = bus.mem_read ^ bus.mem_write;
    assign both_req = bus.mem_read & bus.mem_write;
    assign live_op  = !req ? OP_NONE : (bus.mem_read ? OP_READ : OP_WRITE);

    // In IDLE the live request is the access; afterwards the latched copy is.
    assign cur_op    = in_idle ? live_op : op_q;
    assign cur_addr  = in_idle ? bus.address : addr_q;
    assign cur_wdata = in_idle ? bus.write_data : wdata_q;
    assign cur_byte  = in_idle ? bus.byte_op : byte_q;
    assign cur_err   = in_idle ? (both_req | addr_bad(bus.address, bus.byte_op)) : err_q;
    assign cur_idx   = cur_addr[ADDR_BITS:1];
    assign rd_word   = mem_q[cur_idx];

    assign load_value = cur_err  ? 16'h0000 :
                        cur_byte ? {8'h00, (cur_addr[0] ? rd_word[15:8] : rd_word[7:0])} :
                                   rd_word;

    assign fast_done = (WAIT_CYCLES == 0) && in_idle && req;
    assign slow_done = (state_q == ST_DONE);

    assign bus.stall      = (WAIT_CYCLES != 0) && ((in_idle && req) || (state_q == ST_WAIT));
    assign bus.read_valid = (fast_done || slow_done) && (cur_op == OP_READ);
    assign bus.addr_error = (fast_done || slow_done) && cur_err;
    assign read_data_d    = bus.read_valid ? load_value : read_data_q;
    assign bus.read_data  = read_data_d;

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        byte_d  = byte_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req || both_req) begin
                    op_d    = live_op;
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    byte_d  = bus.byte_op;
                    err_d   = cur_err;
                end
                if (both_req) begin
                    state_d = ST_DONE;
                end else if (req && (WAIT_CYCLES == 1)) begin
                    state_d = ST_DONE;
                end else if (req && (WAIT_CYCLES >= 2)) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Writes land on the edge that enters DONE, or at the end of T when there are no wait states.
    assign wr_en = (cur_op == OP_WRITE) && !cur_err &&
                   (fast_done || ((state_q != ST_DONE) && (state_d == ST_DONE)));

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_q        <= OP_NONE;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            byte_q      <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the array must read as zero after reset, so it is a resettable flop array, not an inferred RAM.
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
        end else if (wr_en) begin
            if (!cur_byte)        mem_q[cur_idx]       <= cur_wdata;
            else if (cur_addr[0]) mem_q[cur_idx][15:8] <= cur_wdata[7:0];
            else                  mem_q[cur_idx][7:0]  <= cur_wdata[7:0];
        end
    end

endmodule
